// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, access size
// codes, byte-enable patterns and the alignment rule used by the optional misalign check.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'h0;
  localparam logic [3:0] BE_BYTE0   = 4'h1;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;
  localparam logic [3:0] BE_WORD    = 4'hF;

  // Size code 3 is handled as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and data replication, plus load
// lane extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter bit LOAD_SIGN_EXT = 1'b1
) (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be        = BE_WORD;
    o_wdata     = i_store_data;
    o_load_data = i_rdata;
    w_byte      = i_rdata[{i_off, 3'b000} +: 8];
    w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: begin
        o_be        = BE_BYTE0 << i_off;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = LOAD_SIGN_EXT ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      end
      SZ_HALF: begin
        o_be        = i_off[1] ? BE_HALF_HI : BE_HALF_LO;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = LOAD_SIGN_EXT ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      end
      default: begin
        o_be        = BE_WORD;
        o_wdata     = i_store_data;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ready data bus and stalls the pipe
// until completion or timeout. Optional misalign trap: define MEM_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit LOAD_SIGN_EXT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ReadData2_in,
  input  logic [1:0]  state_of_type_in,
  input  logic        data_mem_en_in,
  input  logic        wb_data_sel_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic        stall_out,
  output logic        mem_err_out,
  output logic [1:0]  dbg_state_out
);

  // Bus handshake: dmem_req rises with the access and is held, together with
  // we/addr/wdata/be, until the first BUSY cycle that sees dmem_ready (transfer
  // complete, dmem_rdata valid that cycle) or until the timeout aborts it.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  r_state;
  mem_state_t  w_next_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_load;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_data;
  logic        r_err;

  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_misalign;
  logic        w_timeout;

  // Live EX/MEM fields steer lanes when launching; latched ones drive load extraction.
  assign w_size = (r_state == IDLE) ? state_of_type_in : r_size;
  assign w_off  = (r_state == IDLE) ? ALU_result_in[1:0] : r_off;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(state_of_type_in, ALU_result_in[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout = (r_cnt == CNT_LAST);

  mem_lane_align #(
    .LOAD_SIGN_EXT(LOAD_SIGN_EXT)
  ) u_lane_align (
    .i_size      (w_size),
    .i_off       (w_off),
    .i_store_data(ReadData2_in),
    .i_rdata     (dmem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    stall_out    = 1'b0;
    case (r_state)
      IDLE: begin
        stall_out = data_mem_en_in & reset;
        if (data_mem_en_in) w_next_state = w_misalign ? DONE : BUSY;
      end
      BUSY: begin
        stall_out = 1'b1;
        if (dmem_ready || w_timeout) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 8'd0;
      r_size  <= SZ_WORD;
      r_off   <= 2'b00;
      r_load  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= BE_NONE;
      r_data  <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (data_mem_en_in) begin
            r_size <= state_of_type_in;
            r_off  <= ALU_result_in[1:0];
            r_load <= wb_data_sel_in;
            if (w_misalign) begin
              r_err  <= 1'b1;
              r_data <= 32'h0;
            end else begin
              r_req   <= 1'b1;
              r_we    <= ~wb_data_sel_in;
              r_addr  <= {ALU_result_in[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= wb_data_sel_in ? BE_WORD : w_be;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (dmem_ready) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_be  <= BE_NONE;
            if (r_load) r_data <= w_load_data;
          end else if (w_timeout) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_be   <= BE_NONE;
            r_data <= 32'h0;
            r_err  <= 1'b1;
          end
        end
        DONE:    r_cnt <= 8'd0;
        default: r_cnt <= 8'd0;
      endcase
    end
  end

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign dmem_be       = r_be;
  assign mem_data_out  = r_data;
  assign mem_err_out   = r_err;
  assign dbg_state_out = r_state;

endmodule
